// File: rtl/diff_alarm_monitor.sv
// Hysteresis alarm on per-window |avg - sample| results from the averaging stage.
// Also tracks the peak difference, the average seen with it, and a window count.
module diff_alarm_monitor #(
  parameter int W         = 8,
  parameter int THRESH    = 16,
  parameter int TRIP_CNT  = 3,
  parameter int CLEAR_CNT = 2,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          win_done,
  input  logic [W-1:0]  avg_in,
  input  logic [W-1:0]  diff_in,
  input  logic          clr,
  output logic          alarm,
  output logic          alarm_pulse,
  output logic [W-1:0]  peak_diff,
  output logic [W-1:0]  avg_at_peak,
  output logic [CW-1:0] win_cnt,
  output logic [2:0]    hot_run
);

  if (TRIP_CNT < 1 || TRIP_CNT > 7 || CLEAR_CNT < 1) begin : g_bad_cfg
    $error("diff_alarm_monitor: bad TRIP_CNT/CLEAR_CNT");
  end

  localparam int QW = $clog2(CLEAR_CNT + 1);
  localparam logic [W-1:0]  TH      = W'(THRESH);
  localparam logic [2:0]    TRIP    = 3'(TRIP_CNT);
  localparam logic [QW-1:0] CLR_LIM = QW'(CLEAR_CNT);

  typedef enum logic [1:0] {
    NORMAL, PENDING, ALARM, RECOVER
  } state_t;

  state_t        state, state_nx;
  logic [2:0]    hot_nx;
  logic [QW-1:0] quiet, quiet_nx;
  logic          pulse_nx;
  logic          done_q;
  logic          acc;
  logic          hot;

  assign acc = win_done & ~done_q;
  assign hot = diff_in > TH;

  always_comb begin
    state_nx = state;
    hot_nx   = hot_run;
    quiet_nx = quiet;
    pulse_nx = 1'b0;
    if (acc) begin
      unique case (state)
        NORMAL: begin
          if (hot) begin
            hot_nx   = 3'd1;
            state_nx = (TRIP == 3'd1) ? ALARM : PENDING;
          end else begin
            hot_nx = 3'd0;
          end
        end
        PENDING: begin
          if (hot) begin
            hot_nx = hot_run + 3'd1;
            if (hot_nx == TRIP) state_nx = ALARM;
          end else begin
            hot_nx   = 3'd0;
            state_nx = NORMAL;
          end
        end
        ALARM: begin
          if (hot) begin
            if (hot_run < TRIP) hot_nx = hot_run + 3'd1;
          end else begin
            hot_nx   = 3'd0;
            quiet_nx = QW'(1);
            state_nx = RECOVER;
            if (CLR_LIM == QW'(1)) begin
              quiet_nx = '0;
              state_nx = NORMAL;
            end
          end
        end
        RECOVER: begin
          if (hot) begin
            hot_nx   = 3'd1;
            quiet_nx = '0;
            state_nx = ALARM;
          end else begin
            quiet_nx = quiet + QW'(1);
            if (quiet_nx == CLR_LIM) begin
              quiet_nx = '0;
              state_nx = NORMAL;
            end
          end
        end
      endcase
      // Only an entry from the non-alarmed side is a new alarm event.
      pulse_nx = (state == NORMAL || state == PENDING) &&
                 (state_nx == ALARM);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= NORMAL;
      alarm       <= 1'b0;
      alarm_pulse <= 1'b0;
      peak_diff   <= '0;
      avg_at_peak <= '0;
      win_cnt     <= '0;
      hot_run     <= 3'd0;
      quiet       <= '0;
      done_q      <= 1'b1;
    end else begin
      done_q <= win_done;
      if (clr) begin
        state       <= NORMAL;
        alarm       <= 1'b0;
        alarm_pulse <= 1'b0;
        peak_diff   <= '0;
        avg_at_peak <= '0;
        win_cnt     <= '0;
        hot_run     <= 3'd0;
        quiet       <= '0;
      end else begin
        state       <= state_nx;
        hot_run     <= hot_nx;
        quiet       <= quiet_nx;
        alarm       <= (state_nx == ALARM) || (state_nx == RECOVER);
        alarm_pulse <= pulse_nx;
        if (acc) begin
          if (win_cnt != '1) win_cnt <= win_cnt + CW'(1);
          if (diff_in > peak_diff) begin
            peak_diff   <= diff_in;
            avg_at_peak <= avg_in;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_diff_alarm_monitor.sv
// Directed bench for diff_alarm_monitor.
// A second narrow-counter instance covers win_cnt saturation.
module tb_diff_alarm_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        win_done = 1'b1;
  logic [7:0]  avg_in = '0;
  logic [7:0]  diff_in = '0;
  logic        clr = 1'b0;
  logic        alarm, alarm_pulse;
  logic [7:0]  peak_diff, avg_at_peak;
  logic [15:0] win_cnt;
  logic [2:0]  hot_run;

  logic        n_alarm, n_pulse;
  logic [7:0]  n_peak, n_avg;
  logic [3:0]  n_cnt;
  logic [2:0]  n_hot;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  diff_alarm_monitor dut (
    .clk(clk), .rst(rst), .win_done(win_done),
    .avg_in(avg_in), .diff_in(diff_in), .clr(clr),
    .alarm(alarm), .alarm_pulse(alarm_pulse),
    .peak_diff(peak_diff), .avg_at_peak(avg_at_peak),
    .win_cnt(win_cnt), .hot_run(hot_run)
  );

  diff_alarm_monitor #(.CW(4)) dut4 (
    .clk(clk), .rst(rst), .win_done(win_done),
    .avg_in(avg_in), .diff_in(diff_in), .clr(clr),
    .alarm(n_alarm), .alarm_pulse(n_pulse),
    .peak_diff(n_peak), .avg_at_peak(n_avg),
    .win_cnt(n_cnt), .hot_run(n_hot)
  );

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic win(input logic [7:0] d, input logic [7:0] a);
    win_done = 1'b0;
    diff_in  = d;
    avg_in   = a;
    @(negedge clk);
    win_done = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    tests++;
    if (win_cnt !== 16'd0) begin
      failed++; $display("FAIL reset_cnt got %0d exp 0", win_cnt);
    end
    tests++;
    if (alarm !== 1'b0 || hot_run !== 3'd0 || peak_diff !== 8'd0) begin
      failed++;
      $display("FAIL reset_state alarm=%0b hot=%0d peak=%0d exp 0/0/0",
               alarm, hot_run, peak_diff);
    end
    win(8'd5, 8'd1);
    tests++;
    if (win_cnt !== 16'd1 || peak_diff !== 8'd5) begin
      failed++;
      $display("FAIL first_win cnt=%0d peak=%0d exp 1/5", win_cnt, peak_diff);
    end
  endtask

  task automatic test_trip;
    win(8'd20, 8'd2);
    tests++;
    if (alarm !== 1'b0 || hot_run !== 3'd1) begin
      failed++; $display("FAIL trip1 alarm=%0b hot=%0d exp 0/1", alarm, hot_run);
    end
    win(8'd30, 8'd3);
    tests++;
    if (alarm !== 1'b0 || hot_run !== 3'd2) begin
      failed++; $display("FAIL trip2 alarm=%0b hot=%0d exp 0/2", alarm, hot_run);
    end
    win(8'd17, 8'd4);
    tests++;
    if (alarm !== 1'b1 || alarm_pulse !== 1'b1 || hot_run !== 3'd3) begin
      failed++;
      $display("FAIL trip3 alarm=%0b pulse=%0b hot=%0d exp 1/1/3",
               alarm, alarm_pulse, hot_run);
    end
    @(negedge clk);
    tests++;
    if (alarm !== 1'b1 || alarm_pulse !== 1'b0) begin
      failed++;
      $display("FAIL trip_pulse_len alarm=%0b pulse=%0b exp 1/0",
               alarm, alarm_pulse);
    end
  endtask

  task automatic test_recover;
    win(8'd16, 8'd0);
    tests++;
    if (alarm !== 1'b1 || hot_run !== 3'd0) begin
      failed++; $display("FAIL rec1 alarm=%0b hot=%0d exp 1/0", alarm, hot_run);
    end
    win(8'd40, 8'd11);
    tests++;
    if (alarm !== 1'b1 || alarm_pulse !== 1'b0 || hot_run !== 3'd1) begin
      failed++;
      $display("FAIL rec_realarm alarm=%0b pulse=%0b hot=%0d exp 1/0/1",
               alarm, alarm_pulse, hot_run);
    end
    win(8'd10, 8'd0);
    tests++;
    if (alarm !== 1'b1) begin
      failed++; $display("FAIL rec3 alarm=%0b exp 1", alarm);
    end
    win(8'd0, 8'd0);
    tests++;
    if (alarm !== 1'b0 || win_cnt !== 16'd8) begin
      failed++;
      $display("FAIL rec_clear alarm=%0b cnt=%0d exp 0/8", alarm, win_cnt);
    end
    tests++;
    if (peak_diff !== 8'd40 || avg_at_peak !== 8'd11) begin
      failed++;
      $display("FAIL rec_peak peak=%0d avg=%0d exp 40/11", peak_diff, avg_at_peak);
    end
  endtask

  task automatic test_pending;
    win(8'd20, 8'd0);
    win(8'd20, 8'd0);
    tests++;
    if (alarm !== 1'b0 || hot_run !== 3'd2) begin
      failed++; $display("FAIL pend2 alarm=%0b hot=%0d exp 0/2", alarm, hot_run);
    end
    win(8'd16, 8'd0);
    tests++;
    if (alarm !== 1'b0 || hot_run !== 3'd0) begin
      failed++; $display("FAIL pend_eq alarm=%0b hot=%0d exp 0/0", alarm, hot_run);
    end
    win(8'd200, 8'd50);
    tests++;
    if (peak_diff !== 8'd200 || avg_at_peak !== 8'd50) begin
      failed++;
      $display("FAIL peak_new peak=%0d avg=%0d exp 200/50", peak_diff, avg_at_peak);
    end
    win(8'd200, 8'd9);
    tests++;
    if (peak_diff !== 8'd200 || avg_at_peak !== 8'd50 || win_cnt !== 16'd13) begin
      failed++;
      $display("FAIL peak_tie peak=%0d avg=%0d cnt=%0d exp 200/50/13",
               peak_diff, avg_at_peak, win_cnt);
    end
  endtask

  task automatic test_clr;
    win_done = 1'b0;
    diff_in  = 8'd99;
    avg_in   = 8'd77;
    @(negedge clk);
    win_done = 1'b1;
    clr      = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    tests++;
    if (win_cnt !== 16'd0 || peak_diff !== 8'd0 || avg_at_peak !== 8'd0 ||
        hot_run !== 3'd0 || alarm !== 1'b0) begin
      failed++;
      $display("FAIL clr cnt=%0d peak=%0d avg=%0d hot=%0d alarm=%0b exp all 0",
               win_cnt, peak_diff, avg_at_peak, hot_run, alarm);
    end
    win(8'd3, 8'd7);
    tests++;
    if (win_cnt !== 16'd1 || peak_diff !== 8'd3 || hot_run !== 3'd0) begin
      failed++;
      $display("FAIL clr_next cnt=%0d peak=%0d hot=%0d exp 1/3/0",
               win_cnt, peak_diff, hot_run);
    end
    win(8'd20, 8'd0);
    win(8'd20, 8'd0);
    tests++;
    if (alarm !== 1'b0) begin
      failed++; $display("FAIL clr_state alarm=%0b exp 0", alarm);
    end
    win(8'd20, 8'd0);
    tests++;
    if (alarm !== 1'b1 || alarm_pulse !== 1'b1) begin
      failed++;
      $display("FAIL clr_retrip alarm=%0b pulse=%0b exp 1/1", alarm, alarm_pulse);
    end
  endtask

  task automatic test_async_rst;
    #3 rst = 1'b0;
    #1;
    tests++;
    if (alarm !== 1'b0 || win_cnt !== 16'd0 || hot_run !== 3'd0) begin
      failed++;
      $display("FAIL async_rst alarm=%0b cnt=%0d hot=%0d exp 0/0/0",
               alarm, win_cnt, hot_run);
    end
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (win_cnt !== 16'd0) begin
      failed++; $display("FAIL rst_held_done cnt=%0d exp 0", win_cnt);
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 15; i++) win(8'd0, 8'd0);
    tests++;
    if (n_cnt !== 4'hF || win_cnt !== 16'd15) begin
      failed++; $display("FAIL sat15 cnt4=%0d cnt=%0d exp 15/15", n_cnt, win_cnt);
    end
    win(8'd0, 8'd0);
    tests++;
    if (n_cnt !== 4'hF || win_cnt !== 16'd16) begin
      failed++; $display("FAIL sat16 cnt4=%0d cnt=%0d exp 15/16", n_cnt, win_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_trip();
    test_recover();
    test_pending();
    test_clr();
    test_async_rst();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/diff_alarm_monitor.md
Name: diff_alarm_monitor

Overview:
- Downstream consumer of the serial averaging stage.
- Once per completed window, samples the stage's registered average and absolute-difference results, qualified by its done level.
- Runs a hysteresis state machine that raises an alarm after TRIP_CNT consecutive over-threshold windows and clears it after CLEAR_CNT consecutive quiet windows.
- Also keeps peak-difference and window-count statistics for status readout.

Parameters:
- W, 8, width of avg_in / diff_in / peak outputs
- THRESH, 16, excursion threshold; a window is "hot" when diff_in > THRESH (strictly greater)
- TRIP_CNT, 3, consecutive hot windows needed to raise the alarm (>=1)
- CLEAR_CNT, 2, consecutive quiet windows needed to drop the alarm (>=1)
- CW, 16, width of window counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- win_done  in  1  upstream done level; high while upstream is idle/result-valid
- avg_in  in  W  upstream average result, valid when win_done high
- diff_in  in  W  upstream |avg - sample| result, valid when win_done high
- clr  in  1  synchronous clear of state machine and statistics
- alarm  out  1  registered alarm level
- alarm_pulse  out  1  one-cycle pulse on alarm entry
- peak_diff  out  W  max diff_in over accepted windows since reset/clr
- avg_at_peak  out  W  avg_in captured with the current peak_diff
- win_cnt  out  CW  accepted windows, saturating
- hot_run  out  3  current consecutive-hot count (debug)

Behaviour:
- Reset (rst=0, async): state=NORMAL, alarm=0, alarm_pulse=0, peak_diff=0, avg_at_peak=0, win_cnt=0, hot_run=0, quiet count=0, done_q=1.
- Window acceptance: acc = win_done & ~done_q; done_q <= win_done every cycle.
  - done_q resets to 1, so the continuous done-high after reset release is not a window.
  - A new window needs a low->high transition; a held-high win_done is accepted once.
- avg_in/diff_in are sampled in the acc cycle only; all effects are visible the next cycle (1-cycle latency).
- hot = (diff_in > THRESH), unsigned W-bit compare; diff_in == THRESH counts as quiet.
- Statistics on acc:
  - win_cnt += 1, saturating at all-ones.
  - If diff_in > peak_diff: peak_diff <= diff_in and avg_at_peak <= avg_in. Ties keep the earlier capture.
- State machine (transitions on acc only; no change otherwise):
  - NORMAL (alarm=0)
    - hot: hot_run=1; go to ALARM if TRIP_CNT==1, else PENDING.
    - quiet: stay, hot_run=0.
  - PENDING (alarm=0)
    - hot: hot_run+1; go to ALARM when it reaches TRIP_CNT.
    - quiet: NORMAL, hot_run=0.
  - ALARM (alarm=1)
    - hot: stay, hot_run saturates at TRIP_CNT.
    - quiet: quiet=1, hot_run=0; go to NORMAL if CLEAR_CNT==1, else RECOVER.
  - RECOVER (alarm=1)
    - quiet: quiet+1; go to NORMAL (alarm=0) when it reaches CLEAR_CNT.
    - hot: ALARM, quiet=0, hot_run=1.
- alarm is a register equal to (state in {ALARM, RECOVER}).
- alarm_pulse=1 for exactly the cycle after the acc that moves NORMAL/PENDING->ALARM. A RECOVER->ALARM move gives no pulse.
- clr=1 (synchronous):
  - Same values as reset except done_q, which keeps tracking win_done.
  - clr together with acc: clr wins and the window is dropped (not counted, not compared).
- rst asserted mid-window or mid-alarm: immediate clear; the first window after release needs a fresh win_done rise.
- Elaboration must fail if TRIP_CNT<1, CLEAR_CNT<1, or TRIP_CNT>7.

Test Plan:
- Reset release with win_done held 1 for 10 cycles -> win_cnt=0, alarm=0; then win_done 0->1 with diff=5 -> win_cnt=1 next cycle, peak_diff=5.
- Windows diff=20,30,17 (THRESH=16, TRIP=3) -> alarm 0,0 then 1 one cycle after the third acc; alarm_pulse high exactly one cycle; hot_run=3.
- In ALARM, windows diff=16,40,10,0 -> RECOVER, ALARM (no pulse), RECOVER, NORMAL; alarm drops one cycle after the 4th acc.
- Windows diff=20,20,16 -> PENDING, PENDING, NORMAL, no alarm; then diff=200,avg=50 -> peak_diff=200, avg_at_peak=50; a later diff=200,avg=9 leaves avg_at_peak=50.
- clr in the same cycle as an acc with diff=99 -> all stats 0, state NORMAL, window ignored; next window counted as win_cnt=1.
- rst pulsed low asynchronously (not clock-aligned) while in ALARM -> alarm=0 immediately; 65536 windows with CW=16 -> win_cnt stops at 16'hFFFF.
